// File: rtl/multi_dice_roller.sv
// N-die roller: a free-running odometer of FACES-sided counters is sampled while
// roll is held and captured on its release, then decoded for the 7-seg bank.
module multi_dice_roller #(
    parameter int NUM_DICE = 2,
    parameter int FACES    = 6,
    parameter int VW       = $clog2(FACES + 1),
    parameter int SW       = $clog2(NUM_DICE * FACES + 1)
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   roll,
    input  logic                   clear,
    output logic [7*NUM_DICE-1:0]  seg7,
    output logic [VW*NUM_DICE-1:0] value,
    output logic [SW-1:0]          sum,
    output logic                   done,
    output logic                   busy,
    output logic [15:0]            rolls
);

    typedef enum logic [1:0] {IDLE, ROLLING, SHOW} state_t;

    localparam logic [VW-1:0] FACES_V = VW'(FACES);
    localparam logic [VW-1:0] ONE_V   = VW'(1);

    function automatic logic [6:0] seg_decode(input logic [VW-1:0] v);
        case (int'(v))
            1:       return 7'b1111001;
            2:       return 7'b0100100;
            3:       return 7'b0110000;
            4:       return 7'b0011001;
            5:       return 7'b0010010;
            6:       return 7'b0000010;
            7:       return 7'b1111000;
            8:       return 7'b0000000;
            9:       return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    state_t                  state_q, state_d;
    logic [VW*NUM_DICE-1:0]  cnt_q, cnt_d;
    logic [VW*NUM_DICE-1:0]  value_q, value_d;
    logic [SW-1:0]           sum_q, sum_d;
    logic [7*NUM_DICE-1:0]   seg7_q, seg7_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;
    logic [15:0]             rolls_q, rolls_d;
    logic [SW-1:0]           sum_cap;
    logic [7*NUM_DICE-1:0]   seg_cap;
    logic                    carry;

    // Odometer: die i steps only when every lower die is about to wrap.
    always_comb begin
        cnt_d   = cnt_q;
        carry   = 1'b1;
        sum_cap = '0;
        seg_cap = '1;
        for (int i = 0; i < NUM_DICE; i++) begin
            if (carry) begin
                cnt_d[VW*i +: VW] = (cnt_q[VW*i +: VW] == FACES_V) ? ONE_V
                                                                   : cnt_q[VW*i +: VW] + ONE_V;
            end
            carry = carry & (cnt_q[VW*i +: VW] == FACES_V);
            sum_cap = sum_cap + SW'(cnt_q[VW*i +: VW]);
            seg_cap[7*i +: 7] = seg_decode(cnt_q[VW*i +: VW]);
        end
    end

    always_comb begin
        state_d = state_q;
        value_d = value_q;
        sum_d   = sum_q;
        seg7_d  = seg7_q;
        done_d  = 1'b0;
        rolls_d = rolls_q;
        if (clear) begin
            state_d = IDLE;
            value_d = '0;
            sum_d   = '0;
            seg7_d  = '1;
        end else begin
            case (state_q)
                IDLE, SHOW: begin
                    if (roll) state_d = ROLLING;
                end
                ROLLING: begin
                    // Display tumbles every edge; the release edge freezes it.
                    value_d = cnt_q;
                    sum_d   = sum_cap;
                    seg7_d  = seg_cap;
                    if (!roll) begin
                        state_d = SHOW;
                        done_d  = 1'b1;
                        if (rolls_q != 16'hFFFF) rolls_d = rolls_q + 16'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        busy_d = (state_d == ROLLING);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            for (int i = 0; i < NUM_DICE; i++) cnt_q[VW*i +: VW] <= ONE_V;
            value_q <= '0;
            sum_q   <= '0;
            seg7_q  <= '1;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            rolls_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            value_q <= value_d;
            sum_q   <= sum_d;
            seg7_q  <= seg7_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            rolls_q <= rolls_d;
        end
    end

    assign seg7  = seg7_q;
    assign value = value_q;
    assign sum   = sum_q;
    assign done  = done_q;
    assign busy  = busy_q;
    assign rolls = rolls_q;

endmodule

// File: tb/tb_multi_dice_roller.sv
// Directed bench for multi_dice_roller: a 2x6 instance and a 1x9 boundary instance.
module tb_multi_dice_roller;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset_n, roll, clear;
    logic [13:0] a_seg7;
    logic [5:0]  a_value;
    logic [3:0]  a_sum;
    logic        a_done, a_busy;
    logic [15:0] a_rolls;

    logic        reset_n_b, roll_b, clear_b;
    logic [6:0]  b_seg7;
    logic [3:0]  b_value;
    logic [3:0]  b_sum;
    logic        b_done, b_busy;
    logic [15:0] b_rolls;

    int checks = 0;
    int errors = 0;

    multi_dice_roller #(.NUM_DICE(2), .FACES(6)) dut_a (
        .clock(clock), .reset_n(reset_n), .roll(roll), .clear(clear),
        .seg7(a_seg7), .value(a_value), .sum(a_sum), .done(a_done),
        .busy(a_busy), .rolls(a_rolls)
    );

    multi_dice_roller #(.NUM_DICE(1), .FACES(9)) dut_b (
        .clock(clock), .reset_n(reset_n_b), .roll(roll_b), .clear(clear_b),
        .seg7(b_seg7), .value(b_value), .sum(b_sum), .done(b_done),
        .busy(b_busy), .rolls(b_rolls)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_a();
        @(posedge clock);
        #1 reset_n = 1'b0;
        #2 reset_n = 1'b1;
    endtask

    task automatic reset_b();
        @(posedge clock);
        #1 reset_n_b = 1'b0;
        #2 reset_n_b = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (a_seg7 !== 14'h3FFF) begin errors++; $display("FAIL reset_seg7 got %h exp 3fff", a_seg7); end
        checks++; if (a_value !== 6'h00) begin errors++; $display("FAIL reset_value got %h exp 00", a_value); end
        checks++; if (a_sum !== 4'd0) begin errors++; $display("FAIL reset_sum got %0d exp 0", a_sum); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", a_done); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", a_busy); end
        checks++; if (a_rolls !== 16'd0) begin errors++; $display("FAIL reset_rolls got %0d exp 0", a_rolls); end
    endtask

    task automatic test_single_roll();
        reset_a();
        roll = 1'b1;
        step();                                   // edge 1: IDLE -> ROLLING
        checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL roll_busy got %b exp 1", a_busy); end
        checks++; if (a_value !== 6'h00) begin errors++; $display("FAIL roll_value_e1 got %h exp 00", a_value); end
        step();                                   // edge 2: value tracks cnt after 1 edge = {1,2}
        checks++; if (a_value !== 6'h0A) begin errors++; $display("FAIL tumble_value got %h exp 0a", a_value); end
        checks++; if (a_sum !== 4'd3) begin errors++; $display("FAIL tumble_sum got %0d exp 3", a_sum); end
        repeat (7) step();                        // edges 3..9
        roll = 1'b0;
        step();                                   // edge 10: capture N=9 -> {2,4}
        checks++; if (a_value !== 6'h14) begin errors++; $display("FAIL single_value got %h exp 14", a_value); end
        checks++; if (a_sum !== 4'd6) begin errors++; $display("FAIL single_sum got %0d exp 6", a_sum); end
        checks++; if (a_seg7 !== 14'b0100100_0011001) begin errors++; $display("FAIL single_seg7 got %b exp 01001000011001", a_seg7); end
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL single_done got %b exp 1", a_done); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b exp 0", a_busy); end
        checks++; if (a_rolls !== 16'd1) begin errors++; $display("FAIL single_rolls got %0d exp 1", a_rolls); end
        step();
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL single_done_width got %b exp 0", a_done); end
        checks++; if (a_value !== 6'h14) begin errors++; $display("FAIL show_hold got %h exp 14", a_value); end
    endtask

    task automatic test_clear_priority();
        roll  = 1'b1;
        clear = 1'b1;
        step();
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL clear_busy got %b exp 0", a_busy); end
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL clear_done got %b exp 0", a_done); end
        checks++; if (a_value !== 6'h00) begin errors++; $display("FAIL clear_value got %h exp 00", a_value); end
        checks++; if (a_sum !== 4'd0) begin errors++; $display("FAIL clear_sum got %0d exp 0", a_sum); end
        checks++; if (a_seg7 !== 14'h3FFF) begin errors++; $display("FAIL clear_seg7 got %h exp 3fff", a_seg7); end
        checks++; if (a_rolls !== 16'd1) begin errors++; $display("FAIL clear_rolls got %0d exp 1", a_rolls); end
        roll  = 1'b0;
        clear = 1'b0;
        step();
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL clear_idle_done got %b exp 0", a_done); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL clear_idle_busy got %b exp 0", a_busy); end
    endtask

    task automatic test_wrap();
        reset_a();
        checks++; if (a_rolls !== 16'd0) begin errors++; $display("FAIL wrap_reset_rolls got %0d exp 0", a_rolls); end
        repeat (35) step();                       // edges 1..35
        roll = 1'b1;
        step();                                   // edge 36
        roll = 1'b0;
        step();                                   // edge 37: capture N=36 -> {1,1}
        checks++; if (a_value !== 6'h09) begin errors++; $display("FAIL wrap_value got %h exp 09", a_value); end
        checks++; if (a_sum !== 4'd2) begin errors++; $display("FAIL wrap_sum got %0d exp 2", a_sum); end
        checks++; if (a_seg7 !== 14'b1111001_1111001) begin errors++; $display("FAIL wrap_seg7 got %b exp 11110011111001", a_seg7); end
        checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL wrap_done got %b exp 1", a_done); end
    endtask

    task automatic test_saturation();
        logic [15:0] exp_rolls [3];
        exp_rolls[0] = 16'hFFFE;
        exp_rolls[1] = 16'hFFFF;
        exp_rolls[2] = 16'hFFFF;
        force dut_a.rolls_q = 16'hFFFD;
        #1 release dut_a.rolls_q;
        checks++; if (a_rolls !== 16'hFFFD) begin errors++; $display("FAIL sat_preload got %h exp fffd", a_rolls); end
        for (int k = 0; k < 3; k++) begin
            roll = 1'b1;
            step();
            roll = 1'b0;
            step();
            checks++; if (a_rolls !== exp_rolls[k]) begin errors++; $display("FAIL sat_rolls_%0d got %h exp %h", k, a_rolls, exp_rolls[k]); end
            checks++; if (a_done !== 1'b1) begin errors++; $display("FAIL sat_done_%0d got %b exp 1", k, a_done); end
        end
        step();
        checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL sat_done_end got %b exp 0", a_done); end
    endtask

    task automatic test_boundary();
        reset_b();
        roll_b = 1'b1;
        repeat (8) step();                        // edges 1..8
        roll_b = 1'b0;
        step();                                   // edge 9: capture N=8 -> 9
        checks++; if (b_value !== 4'd9) begin errors++; $display("FAIL b_value got %0d exp 9", b_value); end
        checks++; if (b_sum !== 4'd9) begin errors++; $display("FAIL b_sum got %0d exp 9", b_sum); end
        checks++; if (b_seg7 !== 7'b0010000) begin errors++; $display("FAIL b_seg7 got %b exp 0010000", b_seg7); end
        checks++; if (b_done !== 1'b1) begin errors++; $display("FAIL b_done got %b exp 1", b_done); end
        checks++; if (b_rolls !== 16'd1) begin errors++; $display("FAIL b_rolls got %0d exp 1", b_rolls); end
        roll_b = 1'b1;
        step();
        step();
        checks++; if (b_busy !== 1'b1) begin errors++; $display("FAIL b_busy got %b exp 1", b_busy); end
        reset_n_b = 1'b0;
        #1;
        checks++; if (b_seg7 !== 7'h7F) begin errors++; $display("FAIL b_rst_seg7 got %b exp 1111111", b_seg7); end
        checks++; if (b_value !== 4'd0) begin errors++; $display("FAIL b_rst_value got %0d exp 0", b_value); end
        checks++; if (b_sum !== 4'd0) begin errors++; $display("FAIL b_rst_sum got %0d exp 0", b_sum); end
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL b_rst_busy got %b exp 0", b_busy); end
        checks++; if (b_rolls !== 16'd0) begin errors++; $display("FAIL b_rst_rolls got %0d exp 0", b_rolls); end
        roll_b    = 1'b0;
        reset_n_b = 1'b1;
        step();
        checks++; if (b_done !== 1'b0) begin errors++; $display("FAIL b_rst_done got %b exp 0", b_done); end
    endtask

    initial begin
        reset_n   = 1'b0;
        reset_n_b = 1'b0;
        roll      = 1'b0;
        clear     = 1'b0;
        roll_b    = 1'b0;
        clear_b   = 1'b0;
        #12;
        test_reset();
        reset_n   = 1'b1;
        reset_n_b = 1'b1;
        test_single_roll();
        test_clear_priority();
        test_wrap();
        test_saturation();
        test_boundary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_dice_roller.md
# multi_dice_roller

Parametrised N-die roller for the board's seven-segment display bank. It generalises the single six-sided die to NUM_DICE dice of FACES faces each, driven by a free-running odometer counter. A roll handshake (tumble while `roll` is high, capture on release) reports per-die values, their sum, a done pulse and a saturating roll count. It sits between the debounced push-button input and the seven-segment digit drivers.

## Interface
- NUM_DICE, 2, number of dice; legal range 1..8
- FACES, 6, faces per die; legal range 2..9 (one 7-seg digit)
- VW, $clog2(FACES+1), derived: width of one die value
- SW, $clog2(NUM_DICE*FACES+1), derived: width of the sum
- clock  in  1  rising-edge system clock
- reset_n  in  1  asynchronous, active-low reset
- roll  in  1  level request, already debounced and synchronous; high = tumble, falling = capture
- clear  in  1  synchronous clear to IDLE; has priority over roll
- seg7  out  7*NUM_DICE  active-low gfedcba; die i occupies [7i+6:7i]
- value  out  VW*NUM_DICE  die i value at [VW*i+VW-1:VW*i]; 0 = no roll
- sum  out  SW  sum of all value fields
- done  out  1  one-cycle pulse on the capture edge
- busy  out  1  high while in ROLLING
- rolls  out  16  completed-roll count, saturates at 65535

## Operation
- Odometer counter:
  - Per-die counter cnt[i] holds 1..FACES and runs freely in every state.
  - cnt[0] advances on every clock edge.
  - cnt[i] advances on an edge only when cnt[0..i-1] are all at FACES.
  - Wrap is FACES -> 1. After reset all counters are 1.
  - After N edges since reset release: cnt[i] = 1 + (floor(N / FACES^i) mod FACES).
- FSM states: IDLE, ROLLING, SHOW.
  - IDLE: roll=1 -> ROLLING.
  - ROLLING: each edge, value <= current cnt (tumbling display). roll=0 -> capture cnt into value, go to SHOW, pulse done, increment rolls (saturating).
  - SHOW: hold value, sum and seg7; roll=1 -> ROLLING.
  - clear=1 in any state -> IDLE. value, sum and seg7 blank/zero; done stays 0; rolls and counters are untouched.
- Capture semantics: the captured value is the cnt[] value present *before* the capture edge, i.e. the value sampled at that edge.
- sum is registered and updated on the same edge as value. Arithmetic is unsigned at SW bits and cannot overflow by construction.
- Seven-segment decode (active-low, gfedcba), applied per die from its value field:
  - 0 -> 1111111 (blank)
  - 1 -> 1111001
  - 2 -> 0100100
  - 3 -> 0110000
  - 4 -> 0011001
  - 5 -> 0010010
  - 6 -> 0000010
  - 7 -> 1111000
  - 8 -> 0000000
  - 9 -> 0010000
- seg7 is registered and updated on the same edge as value.

## Timing
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, all cnt=1.
  - value=0, sum=0, seg7 all 1s (blank).
  - done=0, busy=0, rolls=0.
- Reset release is synchronous to clock in the surrounding design; the first edge after release is counter edge N=1.
- roll=1 sampled at edge k in IDLE/SHOW:
  - ROLLING from k; busy=1 after k.
  - value first tracks cnt at edge k+1.
- roll=0 sampled at edge m in ROLLING:
  - value, sum and seg7 updated at m; done=1 for exactly the cycle after m; busy=0 after m.
- Minimum legal roll pulse is one cycle: capture happens at the next edge.
- clear and roll both high: clear wins, state=IDLE, no done.
- A capture that would exceed 65535 rolls leaves rolls at 65535; done still pulses.
- Reset asserted mid-ROLLING: all outputs return to reset values immediately, with no done pulse.

## Test plan
- Reset check, NUM_DICE=2, FACES=6 -> seg7=14'h3FFF, value=0, sum=0, done=0, busy=0, rolls=0.
- Single roll:
  - Stimulus: NUM_DICE=2, FACES=6; release reset; drive roll high for edges 1..9; the capture edge is edge 10 (N=9 before it).
  - Required: value die0=4, die1=2; sum=6; seg7={0100100,0011001}; done high exactly one cycle; rolls=1.
- Wrap and odometer: free-run 36 edges with no roll -> internal cnt back to {1,1}. A capture then yields value {1,1}, sum=2, seg7 die0=die1=1111001.
- Clear priority:
  - Stimulus: in SHOW, assert roll and clear together.
  - Required: state IDLE, seg7 blank, value=0, sum=0, no done, rolls unchanged.
- Boundary parameters: NUM_DICE=1, FACES=9, capture at counter value 9 -> value=9, sum=9, seg7=0010000. Reset asserted mid-ROLLING -> immediate blank, rolls=0.
- Saturation: force 65536 captures -> rolls=65535; done pulses on the final capture.
